hx8357_seq: RTL
===============

# hx8357_seq

Command sequencer for the HX8357 parallel display write controller. After reset it plays the panel power-up sequence, then fills rectangular windows with a single 16-bit colour on request. It drives the controller's `cmd`, `data` and `data_in` inputs and paces every word on the controller's `transmission_cmpl` pulse. It sits between the application logic and the controller instance, which is instantiated alongside it, not inside it.

## Interface
- `H_RES`, 320, panel width in pixels
- `V_RES`, 480, panel height in pixels
- `WAIT_CYC`, 12_000_000, clk cycles waited after SWRESET and after SLPOUT (120 ms at 100 MHz)
- `clk`  in  1  clock
- `nres`  in  1  reset; one clock, reset asynchronous and active-low
- `start`  in  1  fill request, sampled only while `ready`=1
- `x0`, `x1`  in  16 each  inclusive column bounds
- `y0`, `y1`  in  16 each  inclusive row bounds
- `color`  in  16  RGB565 fill value, captured on accepted `start`
- `ready`  out  1  high when idle and accepting `start`
- `done`  out  1  one-cycle pulse after the last pixel word completes
- `err`  out  1  one-cycle pulse when `start` is rejected for bad bounds
- `cmd`  out  1  to controller: send current word as a command
- `data`  out  1  to controller: send current word as data
- `data_in`  out  16  to controller: current word
- `transmission_cmpl`  in  1  from controller: current word sampled

## Operation
- Reset values: `ready`=0, `done`=0, `err`=0, `cmd`=0, `data`=0, `data_in`=0. The state is INIT_SWRST. All outputs are registered.
- Word handshake:
  - Drive exactly one of `cmd`/`data` high with `data_in` valid.
  - Hold both until `transmission_cmpl`=1.
  - On that same edge, load the next word and strobe. If no word follows, drop both strobes to 0.
  - `cmd` and `data` are never high together.
- Init sequence:
  - INIT_SWRST (C 0x01) -> WAIT1 (`WAIT_CYC` cycles, strobes low)
  - -> INIT_SLPOUT (C 0x11) -> WAIT2
  - -> INIT_COLMOD (C 0x3A, then D 0x0055)
  - -> INIT_DISPON (C 0x29) -> READY
- READY: `ready`=1. An accepted `start` captures bounds and colour. The bounds check is then:
  - Reject when `x1`<`x0`, `y1`<`y0`, `x1`>=`H_RES` or `y1`>=`V_RES`. Pulse `err`, stay in READY.
  - Otherwise go to CASET.
- Fill sequence:
  - CASET: C 0x2A, then D `x0[15:8]`, `x0[7:0]`, `x1[15:8]`, `x1[7:0]`, each zero-extended to 16 bits.
  - PASET: C 0x2B, then the same pattern for `y0`/`y1`.
  - RAMWR: C 0x2C.
  - PIX: D `color`, repeated N times, where N=(x1-x0+1)*(y1-y0+1).
  - DONE: pulse `done`, return to READY.
- The strobe stays asserted across all words of the fill, so the controller chains words without returning to IDLE.
- Arithmetic: the pixel counter is `$clog2(H_RES*V_RES+1)` bits wide. Extents are computed at the counter width, and the product is truncated to that width. The counter counts N down to 0 and decrements on each PIX `transmission_cmpl`.
- `start` while `ready`=0 is ignored, with no queuing.
- `start`, bounds and `color` changes after acceptance have no effect.
- Reset asserted mid-operation: outputs return to reset values immediately and the full init sequence replays.

## Timing
- Controller cost per word:
  - 2 cycles when the word has the same type as the previous one.
  - 3 cycles when the type changes.
  - 4 cycles for the first word after controller IDLE.
- Cycle counts use `WAIT_CYC`=8:
  - From `nres` release, SWRESET `cmd` is asserted in cycle 0.
  - WAIT1 starts on the cycle after SWRESET `transmission_cmpl`, and lasts exactly 8 cycles with `cmd`=`data`=0.
- `start` to first CASET `cmd`=1: 1 cycle.
- Last PIX `transmission_cmpl` to `done`: 1 cycle. `ready` rises in the cycle after `done`.
- `err` fires 1 cycle after the rejected `start`, and `ready` stays high throughout.

## Structure
- Package `hx8357_pkg`:
  - Opcode constants SWRESET, SLPOUT, COLMOD, DISPON, CASET, PASET, RAMWR.
  - `COLMOD_565`=0x55.
  - The sequencer state enum.
- No sub-module. The wait counter and pixel counter are inline. A single byte-index counter (0..4) selects the word within CASET/PASET/COLMOD.

## Test plan
- Reset release with `WAIT_CYC`=8 and the controller model attached:
  - Words 0x01, 0x11, 0x3A, 0x55, 0x29 appear in order, with DC types C, C, C, D, C.
  - Gaps are 8 idle cycles after 0x01 and after 0x11.
  - `ready`=1 after 0x29.
- Fill x=2..3, y=5..5, color 0xF800:
  - Words are 2A, 00, 02, 00, 03, 2B, 00, 05, 00, 05, 2C, then F800 twice.
  - `done` pulses once and `ready` then returns high.
- Full-screen fill 0..319 x 0..479: exactly 153600 pixel words, followed by `done`.
- Bad bounds x0=10, x1=9: `err` pulses, no strobe is asserted, `ready` stays 1.
- `start` pulsed during a fill: ignored, and exactly N pixel words are still sent.
- `nres` low in the middle of PIX: outputs go to reset values within the same cycle, and the init sequence replays from 0x01.

Source files
------------

// File: rtl/hx8357_pkg.sv
// hx8357_pkg: opcodes, pixel-format constant, sequencer states and window byte selector
package hx8357_pkg;
  localparam logic [7:0] SWRESET    = 8'h01;
  localparam logic [7:0] SLPOUT     = 8'h11;
  localparam logic [7:0] COLMOD     = 8'h3A;
  localparam logic [7:0] DISPON     = 8'h29;
  localparam logic [7:0] CASET      = 8'h2A;
  localparam logic [7:0] PASET      = 8'h2B;
  localparam logic [7:0] RAMWR      = 8'h2C;
  localparam logic [7:0] COLMOD_565 = 8'h55;

  typedef enum logic [3:0] {
    ST_INIT_SWRST, ST_WAIT1, ST_INIT_SLPOUT, ST_WAIT2, ST_INIT_COLMOD, ST_INIT_DISPON,
    ST_READY, ST_CASET, ST_PASET, ST_RAMWR, ST_PIX, ST_DONE
  } state_t;

  // Window words 1..4: lo[15:8], lo[7:0], hi[15:8], hi[7:0], zero-extended
  function automatic logic [15:0] win_byte(input logic [15:0] lo, input logic [15:0] hi, input logic [2:0] idx);
    return {8'h00, idx == 3'd1 ? lo[15:8] : idx == 3'd2 ? lo[7:0] : idx == 3'd3 ? hi[15:8] : hi[7:0]};
  endfunction
endpackage

// File: rtl/hx8357_seq.sv
// hx8357_seq: power-up sequence and rectangular solid fills for an HX8357 write controller
import hx8357_pkg::*;

module hx8357_seq #(
  parameter int H_RES    = 320,
  parameter int V_RES    = 480,
  parameter int WAIT_CYC = 12_000_000
) (
  input  logic        clk,
  input  logic        nres,
  input  logic        start,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  input  logic [15:0] y0,
  input  logic [15:0] y1,
  input  logic [15:0] color,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic        cmd,
  output logic        data,
  output logic [15:0] data_in,
  input  logic        transmission_cmpl
);
  localparam int PIX_W  = $clog2(H_RES * V_RES + 1);
  localparam int WAIT_W = $clog2(WAIT_CYC + 1);

  state_t            r_state, w_state_nx;
  logic [2:0]        r_idx, w_idx_nx;
  logic [WAIT_W-1:0] r_wait;
  logic [PIX_W-1:0]  r_pix, w_dx, w_dy, w_n;
  logic [15:0]       r_x0, r_x1, r_y0, r_y1, r_color;
  logic              r_ready, r_done, r_err, r_cmd, r_data;
  logic [15:0]       r_word, w_word_nx;
  logic              w_bad, w_accept, w_wait_end, w_cmd_nx, w_data_nx, w_err_nx;

  assign w_bad      = x1 < x0 || y1 < y0 || int'(x1) >= H_RES || int'(y1) >= V_RES;
  assign w_accept   = r_state == ST_READY && start && !w_bad;
  assign w_err_nx   = r_state == ST_READY && start && w_bad;
  assign w_wait_end = r_wait == WAIT_W'(WAIT_CYC - 1);
  assign w_dx       = PIX_W'(x1) - PIX_W'(x0) + PIX_W'(1);
  assign w_dy       = PIX_W'(y1) - PIX_W'(y0) + PIX_W'(1);
  assign w_n        = w_dx * w_dy;

  always_ff @(posedge clk or negedge nres)
    if (!nres) begin
      r_state <= ST_INIT_SWRST;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
    end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    case (r_state)
      ST_INIT_SWRST:  if (transmission_cmpl) w_state_nx = ST_WAIT1;
      ST_WAIT1:       if (w_wait_end) w_state_nx = ST_INIT_SLPOUT;
      ST_INIT_SLPOUT: if (transmission_cmpl) w_state_nx = ST_WAIT2;
      ST_WAIT2:       if (w_wait_end) w_state_nx = ST_INIT_COLMOD;
      ST_INIT_COLMOD: if (transmission_cmpl) begin
        w_idx_nx   = r_idx == 3'd1 ? 3'd0 : r_idx + 3'd1;
        w_state_nx = r_idx == 3'd1 ? ST_INIT_DISPON : ST_INIT_COLMOD;
      end
      ST_INIT_DISPON: if (transmission_cmpl) w_state_nx = ST_READY;
      ST_READY:       if (w_accept) w_state_nx = ST_CASET;
      ST_CASET:       if (transmission_cmpl) begin
        w_idx_nx   = r_idx == 3'd4 ? 3'd0 : r_idx + 3'd1;
        w_state_nx = r_idx == 3'd4 ? ST_PASET : ST_CASET;
      end
      ST_PASET:       if (transmission_cmpl) begin
        w_idx_nx   = r_idx == 3'd4 ? 3'd0 : r_idx + 3'd1;
        w_state_nx = r_idx == 3'd4 ? ST_RAMWR : ST_PASET;
      end
      ST_RAMWR:       if (transmission_cmpl) w_state_nx = ST_PIX;
      ST_PIX:         if (transmission_cmpl && r_pix == PIX_W'(1)) w_state_nx = ST_DONE;
      ST_DONE:        w_state_nx = ST_READY;
      default:        w_state_nx = ST_INIT_SWRST;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes change on the completing edge
  always_comb begin
    w_cmd_nx  = 1'b0;
    w_data_nx = 1'b0;
    w_word_nx = '0;
    case (w_state_nx)
      ST_INIT_SWRST:  begin w_cmd_nx = 1'b1; w_word_nx = {8'h00, SWRESET}; end
      ST_INIT_SLPOUT: begin w_cmd_nx = 1'b1; w_word_nx = {8'h00, SLPOUT}; end
      ST_INIT_COLMOD: begin
        w_cmd_nx  = w_idx_nx == 3'd0;
        w_data_nx = w_idx_nx != 3'd0;
        w_word_nx = {8'h00, w_idx_nx == 3'd0 ? COLMOD : COLMOD_565};
      end
      ST_INIT_DISPON: begin w_cmd_nx = 1'b1; w_word_nx = {8'h00, DISPON}; end
      ST_CASET: begin
        w_cmd_nx  = w_idx_nx == 3'd0;
        w_data_nx = w_idx_nx != 3'd0;
        w_word_nx = w_idx_nx == 3'd0 ? {8'h00, CASET} : win_byte(r_x0, r_x1, w_idx_nx);
      end
      ST_PASET: begin
        w_cmd_nx  = w_idx_nx == 3'd0;
        w_data_nx = w_idx_nx != 3'd0;
        w_word_nx = w_idx_nx == 3'd0 ? {8'h00, PASET} : win_byte(r_y0, r_y1, w_idx_nx);
      end
      ST_RAMWR:       begin w_cmd_nx = 1'b1; w_word_nx = {8'h00, RAMWR}; end
      ST_PIX:         begin w_data_nx = 1'b1; w_word_nx = r_color; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nres)
    if (!nres) begin
      r_cmd   <= 1'b0;
      r_data  <= 1'b0;
      r_word  <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cmd   <= w_cmd_nx;
      r_data  <= w_data_nx;
      r_word  <= w_word_nx;
      r_ready <= w_state_nx == ST_READY;
      r_done  <= w_state_nx == ST_DONE;
      r_err   <= w_err_nx;
    end

  always_ff @(posedge clk or negedge nres)
    if (!nres) begin
      r_wait  <= '0;
      r_pix   <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else begin
      r_wait <= (r_state == ST_WAIT1 || r_state == ST_WAIT2) && !w_wait_end ? r_wait + 1'b1 : '0;
      if (w_accept) begin
        r_x0    <= x0;
        r_x1    <= x1;
        r_y0    <= y0;
        r_y1    <= y1;
        r_color <= color;
        r_pix   <= w_n;
      end else if (r_state == ST_PIX && transmission_cmpl)
        r_pix <= r_pix - 1'b1;
    end

  assign ready   = r_ready;
  assign done    = r_done;
  assign err     = r_err;
  assign cmd     = r_cmd;
  assign data    = r_data;
  assign data_in = r_word;
endmodule
